// File: rtl/cnt_seq_ctrl.sv
// Sequencing controller for the lab binary counter: start/run/pause/stop/terminal
// phases with a prescaled tick, up/down stepping and one-shot or auto-reload.
module cnt_seq_ctrl #(
    parameter int CNT_BIT_WIDTH = 4,
    parameter int PRE_BIT_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     stop,
    input  logic                     pause,
    input  logic                     up_dn,
    input  logic                     auto_reload,
    input  logic [CNT_BIT_WIDTH-1:0] start_val,
    input  logic [CNT_BIT_WIDTH-1:0] end_val,
    input  logic [PRE_BIT_WIDTH-1:0] prescale,
    output logic [CNT_BIT_WIDTH-1:0] out,
    output logic                     busy,
    output logic                     done,
    output logic [1:0]               state
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10,
        ST_DONE  = 2'b11
    } state_t;

    localparam logic [CNT_BIT_WIDTH-1:0] CNT_ZERO = {CNT_BIT_WIDTH{1'b0}};
    localparam logic [CNT_BIT_WIDTH-1:0] CNT_ONE  = {{(CNT_BIT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [PRE_BIT_WIDTH-1:0] PRE_ZERO = {PRE_BIT_WIDTH{1'b0}};
    localparam logic [PRE_BIT_WIDTH-1:0] PRE_ONE  = {{(PRE_BIT_WIDTH-1){1'b0}}, 1'b1};

    state_t                     state_r, state_s;
    logic [CNT_BIT_WIDTH-1:0]   out_r, out_s;
    logic                       done_r, done_s;
    logic [PRE_BIT_WIDTH-1:0]   pre_cnt_r, pre_cnt_s;
    logic [CNT_BIT_WIDTH-1:0]   start_lat_r, start_lat_s;
    logic [CNT_BIT_WIDTH-1:0]   end_lat_r, end_lat_s;
    logic [PRE_BIT_WIDTH-1:0]   pre_lat_r, pre_lat_s;
    logic                       up_lat_r, up_lat_s;
    logic                       reload_lat_r, reload_lat_s;

    // State, count, prescaler and latched-settings registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            out_r        <= CNT_ZERO;
            done_r       <= 1'b0;
            pre_cnt_r    <= PRE_ZERO;
            start_lat_r  <= CNT_ZERO;
            end_lat_r    <= CNT_ZERO;
            pre_lat_r    <= PRE_ZERO;
            up_lat_r     <= 1'b0;
            reload_lat_r <= 1'b0;
        end else begin
            state_r      <= state_s;
            out_r        <= out_s;
            done_r       <= done_s;
            pre_cnt_r    <= pre_cnt_s;
            start_lat_r  <= start_lat_s;
            end_lat_r    <= end_lat_s;
            pre_lat_r    <= pre_lat_s;
            up_lat_r     <= up_lat_s;
            reload_lat_r <= reload_lat_s;
        end
    end

    // Next-state and datapath: stop beats start beats pause beats stepping.
    always_comb begin
        state_s      = state_r;
        out_s        = out_r;
        done_s       = 1'b0;
        pre_cnt_s    = pre_cnt_r;
        start_lat_s  = start_lat_r;
        end_lat_s    = end_lat_r;
        pre_lat_s    = pre_lat_r;
        up_lat_s     = up_lat_r;
        reload_lat_s = reload_lat_r;

        if (stop) begin
            state_s   = ST_IDLE;
            pre_cnt_s = PRE_ZERO;
        end else if (start) begin
            start_lat_s  = start_val;
            end_lat_s    = end_val;
            pre_lat_s    = prescale;
            up_lat_s     = up_dn;
            reload_lat_s = auto_reload;
            out_s        = start_val;
            pre_cnt_s    = PRE_ZERO;
            state_s      = ST_RUN;
        end else begin
            case (state_r)
                ST_RUN: begin
                    if (pause) begin
                        state_s = ST_PAUSE;
                    end else if (pre_cnt_r < pre_lat_r) begin
                        pre_cnt_s = pre_cnt_r + PRE_ONE;
                    end else begin
                        pre_cnt_s = PRE_ZERO;
                        if (out_r == end_lat_r) begin
                            done_s = 1'b1;
                            if (reload_lat_r) begin
                                out_s = start_lat_r;
                            end else begin
                                state_s = ST_DONE;
                            end
                        end else if (up_lat_r) begin
                            out_s = out_r + CNT_ONE;
                        end else begin
                            out_s = out_r - CNT_ONE;
                        end
                    end
                end
                // Resume edge leaves the prescaler untouched, so it costs one cycle.
                ST_PAUSE: begin
                    if (pause) begin
                        state_s = ST_PAUSE;
                    end else begin
                        state_s = ST_RUN;
                    end
                end
                ST_IDLE: state_s = ST_IDLE;
                ST_DONE: state_s = ST_DONE;
                default: state_s = ST_IDLE;
            endcase
        end
    end

    assign out   = out_r;
    assign done  = done_r;
    assign state = state_r;
    assign busy  = (state_r == ST_RUN) || (state_r == ST_PAUSE);

endmodule

// File: tb/tb_cnt_seq_ctrl.sv
// Self-checking bench for cnt_seq_ctrl: directed test-plan steps plus a random
// phase, all compared against a cycle-level behavioural model.
module tb_cnt_seq_ctrl;

    localparam int W   = 4;
    localparam int P   = 8;
    localparam int MOD = 1 << W;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           start = 1'b0, stop = 1'b0, pause = 1'b0;
    logic           up_dn = 1'b0, auto_reload = 1'b0;
    logic [W-1:0]   start_val = '0, end_val = '0;
    logic [P-1:0]   prescale = '0;
    logic [W-1:0]   out;
    logic           busy, done;
    logic [1:0]     state;

    int errors = 0;
    int checks = 0;

    // model: mode 0 idle, 1 run, 2 pause, 3 done; elapsed = unpaused run cycles since last tick
    int m_out, m_mode, m_elapsed, m_done;
    int l_start, l_end, l_up, l_rel, l_pre;

    int exp_up_out[6]    = '{3, 4, 5, 6, 6, 6};
    int exp_up_done[6]   = '{0, 0, 0, 0, 1, 0};
    int exp_up_state[6]  = '{1, 1, 1, 1, 3, 3};
    int exp_dn_out[9]    = '{1, 0, 15, 14, 1, 0, 15, 14, 1};
    int exp_dn_done[9]   = '{0, 0, 0, 0, 1, 0, 0, 0, 1};

    cnt_seq_ctrl #(.CNT_BIT_WIDTH(W), .PRE_BIT_WIDTH(P)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .pause(pause),
        .up_dn(up_dn), .auto_reload(auto_reload), .start_val(start_val),
        .end_val(end_val), .prescale(prescale), .out(out), .busy(busy),
        .done(done), .state(state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_out = 0; m_mode = 0; m_elapsed = 0; m_done = 0;
        l_start = 0; l_end = 0; l_up = 0; l_rel = 0; l_pre = 0;
    endtask

    task automatic model_step();
        m_done = 0;
        if (stop) begin
            m_mode = 0;
            m_elapsed = 0;
        end else if (start) begin
            l_start = int'(start_val); l_end = int'(end_val);
            l_up = int'(up_dn); l_rel = int'(auto_reload); l_pre = int'(prescale);
            m_out = l_start;
            m_elapsed = 0;
            m_mode = 1;
        end else if (m_mode == 1 && pause) begin
            m_mode = 2;
        end else if (m_mode == 2 && !pause) begin
            m_mode = 1;
        end else if (m_mode == 1) begin
            m_elapsed++;
            if (m_elapsed == l_pre + 1) begin
                m_elapsed = 0;
                if (m_out == l_end) begin
                    m_done = 1;
                    if (l_rel != 0) m_out = l_start;
                    else m_mode = 3;
                end else begin
                    m_out = (m_out + (l_up != 0 ? 1 : MOD - 1)) % MOD;
                end
            end
        end
    endtask

    task automatic check_model();
        check("model_out", 32'(out), 32'(m_out));
        check("model_state", 32'(state), 32'(m_mode));
        check("model_busy", 32'(busy), 32'((m_mode == 1) || (m_mode == 2)));
        check("model_done", 32'(done), 32'(m_done));
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        check_model();
    endtask

    task automatic go(input int sv, input int ev, input bit up, input bit rel, input int pre);
        start_val = W'(sv); end_val = W'(ev); up_dn = up; auto_reload = rel;
        prescale = P'(pre);
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    initial begin
        model_reset();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("reset_out", 32'(out), 32'd0);
        check("reset_state", 32'(state), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        rst_n = 1'b1;

        // one-shot up 3..6
        go(3, 6, 1'b1, 1'b0, 0);
        for (int i = 0; i < 6; i++) begin
            if (i > 0) cyc();
            check("oneshot_out", 32'(out), 32'(exp_up_out[i]));
            check("oneshot_done", 32'(done), 32'(exp_up_done[i]));
            check("oneshot_state", 32'(state), 32'(exp_up_state[i]));
        end
        check("oneshot_busy", 32'(busy), 32'd0);

        // down with wrap and reload
        go(1, 14, 1'b0, 1'b1, 0);
        for (int i = 0; i < 9; i++) begin
            if (i > 0) cyc();
            check("reload_out", 32'(out), 32'(exp_dn_out[i]));
            check("reload_done", 32'(done), 32'(exp_dn_done[i]));
            check("reload_state", 32'(state), 32'd1);
        end

        // prescale 2
        go(0, 15, 1'b1, 1'b0, 2);
        for (int i = 0; i < 10; i++) begin
            if (i > 0) cyc();
            check("prescale_out", 32'(out), 32'(i / 3));
        end

        // pause at 2
        go(0, 15, 1'b1, 1'b0, 0);
        cyc();
        cyc();
        check("pre_pause_out", 32'(out), 32'd2);
        pause = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc();
            check("pause_state", 32'(state), 32'd2);
            check("pause_out", 32'(out), 32'd2);
        end
        pause = 1'b0;
        cyc();
        check("resume_state", 32'(state), 32'd1);
        check("resume_out", 32'(out), 32'd2);
        cyc();
        check("resume_step", 32'(out), 32'd3);

        // start and stop together: stop wins, out holds
        start_val = 4'd9; start = 1'b1; stop = 1'b1;
        cyc();
        start = 1'b0; stop = 1'b0;
        check("prio_state", 32'(state), 32'd0);
        check("prio_out", 32'(out), 32'd3);

        // stop on the terminal-tick edge suppresses done
        go(9, 9, 1'b1, 1'b0, 0);
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        check("stop_term_done", 32'(done), 32'd0);
        check("stop_term_state", 32'(state), 32'd0);

        // start in DONE
        go(4, 4, 1'b1, 1'b0, 0);
        cyc();
        check("reach_done_state", 32'(state), 32'd3);
        check("reach_done_pulse", 32'(done), 32'd1);
        go(9, 12, 1'b1, 1'b0, 0);
        check("restart_out", 32'(out), 32'd9);
        check("restart_state", 32'(state), 32'd1);

        // async reset mid-run with out=5, no clock edge
        go(5, 10, 1'b1, 1'b0, 3);
        check("prereset_out", 32'(out), 32'd5);
        rst_n = 1'b0;
        #1;
        model_reset();
        check("areset_out", 32'(out), 32'd0);
        check("areset_state", 32'(state), 32'd0);
        check("areset_busy", 32'(busy), 32'd0);
        check("areset_done", 32'(done), 32'd0);
        #1;
        rst_n = 1'b1;

        // random stimulus against the model
        for (int n = 0; n < 3000; n++) begin
            start       = ($urandom_range(0, 14) == 0);
            stop        = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 5) == 0) pause = ~pause;
            up_dn       = 1'($urandom);
            auto_reload = 1'($urandom);
            start_val   = W'($urandom);
            end_val     = W'($urandom);
            prescale    = P'($urandom_range(0, 3));
            cyc();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cnt_seq_ctrl.md
# cnt_seq_ctrl

Programmable sequencing controller for the lab binary-counter datapath. It owns a count register and drives it through start, run, pause, stop and terminal-count phases. It supports up/down direction, a programmable start/end window, one-shot or auto-reload operation and a clock-enable prescaler. It sits between the board control logic (buttons/switches after debouncing) and the display/decoder logic that consumes `out`.

## Interface
- `CNT_BIT_WIDTH`, default 4: width W of the count register and window bounds.
- `PRE_BIT_WIDTH`, default 8: width P of the prescaler setting and its internal counter.

- `clk` input 1: clock; all state changes on its rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: begin or restart a sequence, sampled each edge.
- `stop` input 1: abort to IDLE, sampled each edge.
- `pause` input 1: level; holds the count while high during RUN/PAUSE.
- `up_dn` input 1: 1 counts up, 0 counts down; latched on start.
- `auto_reload` input 1: 1 selects reload at terminal count, 0 selects one-shot; latched on start.
- `start_val` input W: first value of the sequence; latched on start.
- `end_val` input W: terminal value; latched on start.
- `prescale` input P: one count tick every `prescale`+1 cycles; latched on start.
- `out` output W: count value, registered.
- `busy` output 1: high in RUN or PAUSE.
- `done` output 1: one-cycle pulse on a terminal-count tick, registered.
- `state` output 2: IDLE=00, RUN=01, PAUSE=10, DONE=11.

## Operation
- **Reset (async):** `out`=0, `state`=IDLE, `busy`=0, `done`=0. The prescaler counter and all latched settings clear to 0.
- **Command priority per edge:** `stop` > `start` > `pause` > normal stepping.
- **stop:** accepted in any state. Next state is IDLE, `out` holds its value, the prescaler clears and no `done` is issued.
- **start:** accepted in IDLE, RUN, PAUSE or DONE. It latches `start_val`, `end_val`, `up_dn`, `auto_reload` and `prescale`. It sets `out`=`start_val`, clears the prescaler and enters RUN.
- **IDLE / DONE:** `out` holds. DONE keeps the terminal value.
- **RUN with `pause`=1:** go to PAUSE. The prescaler holds and no tick occurs on that edge.
- **RUN with `pause`=0:**
  - If the prescaler is below the latched prescale, it increments.
  - Otherwise a tick occurs and the prescaler clears to 0.
- **Tick handling:**
  - If `out`==latched end: `done`=1 for the next cycle. With auto-reload, `out`=latched start and the block stays in RUN. Without auto-reload, the block goes to DONE and `out` holds.
  - Otherwise `out` = `out`±1 modulo 2^W. Up wraps 2^W−1→0; down wraps 0→2^W−1.
- **PAUSE:** with `pause`=0 the block returns to RUN. The prescaler holds on that edge, so resume costs one cycle. With `pause`=1 it stays in PAUSE.
- **Window:** `end_val` is always reachable through wrap-around. `start_val`==`end_val` is legal; the first tick is then terminal.

## Timing
- Latency from start to first value: `start` high at edge k gives `out`=`start_val` after edge k.
- First step: the first tick is at edge k+`prescale`+1 if no pause intervenes. Ticks then repeat every `prescale`+1 unpaused RUN cycles.
- `done` is registered. It is high exactly in the cycle following the terminal tick edge, alongside the reload value or DONE state. It is low in every other cycle.
- A `start` or `stop` on the terminal-tick edge overrides the tick, and no `done` is issued.
- Changing the inputs during a run has no effect until the next `start`.
- `busy` and `state` decode from the state register with no combinational input path.

## Test plan
- **Reset:** `rst_n`=0 mid-RUN with `out`=5, asynchronously and without a clock edge. Required: immediately `out`=0, `state`=00, `busy`=0, `done`=0.
- **One-shot up:** W=4, start_val=3, end_val=6, prescale=0, up_dn=1, auto_reload=0, start pulse. Required: `out` reads 3,4,5,6 on consecutive cycles, then stays 6. `done` is high for one cycle with `state`=11, and `busy` then goes to 0.
- **Down with wrap and reload:** start_val=1, end_val=14, up_dn=0, auto_reload=1, prescale=0. Required: `out` reads 1,0,15,14,1,0,15,14. `done` pulses in each cycle showing the reload value 1, and `state` stays 01.
- **Prescale:** prescale=2, start_val=0, end_val=15, up. Required: `out` steps every 3 cycles (0,0,0,1,1,1,2…).
- **Pause:** with prescale=0, assert `pause` for 4 cycles at `out`=2. Required: `state`=10 and `out` frozen at 2. After release, one cycle at RUN with `out`=2, then 3.
- **Priority:**
  - `start` and `stop` together in RUN: next `state`=00 and `out` holds.
  - `start` in DONE with new start_val=9: `out`=9 and `state`=01 next cycle.
